// File: rtl/qbert_row_menu.sv
// qbert_row_menu
// Attract-mode title-screen renderer. Draws a row of N_CUBES isometric cubes
// and an automatic Q*bert that hops back and forth along the row. Each landing
// advances the landed cube's top colour through the palette. With
// QBERT_WIN_EN defined, the block also detects when every top equals
// TARGET_COLOR and then runs a timed level-complete sequence.
//
// Ports
//   clk        in   pixel clock
//   reset      in   synchronous, active-high
//   x_cnt      in   [10:0] current pixel x
//   y_cnt      in   [9:0]  current pixel y
//   menu_RGB   out  [23:0] pixel colour {R,G,B}, 2 cycles after x_cnt/y_cnt
//   hop_done   out  one-cycle pulse during each landing (LAND) cycle
//   level_done out  high throughout the level-complete sequence
//   qbert_idx  out  [2:0] cube Q*bert stands on or last left
//
// Build option: QBERT_WIN_EN enables completion detection, the WIN state and
// the flashing background. Without it, colours simply wrap and level_done is 0.

module qbert_row_menu #(
    parameter int N_CUBES      = 4,
    parameter int N_COLORS     = 5,
    parameter int TARGET_COLOR = 1,
    parameter int X0           = 110,
    parameter int Y0           = 350,
    parameter int XD           = 80,
    parameter int YD           = 100,
    parameter int XLEN         = 100,
    parameter int Q_HX         = 20,
    parameter int Q_HY         = 20,
    parameter int HOP_H        = 40,
    parameter int IDLE_TICKS   = 8000000,
    parameter int STEP_TICKS   = 131072,
    parameter int WIN_TICKS    = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x_cnt,
    input  logic [9:0]  y_cnt,
    output logic [23:0] menu_RGB,
    output logic        hop_done,
    output logic        level_done,
    output logic [2:0]  qbert_idx
);

    localparam logic [20:0] XT_W      = 21'(X0 + XD);
    localparam logic [20:0] XD_W      = 21'(XD);
    localparam logic [20:0] YD_W      = 21'(YD);
    localparam logic [20:0] XLEN_W    = 21'(XLEN);
    localparam logic [20:0] AREA_W    = 21'(XD * YD);
    localparam logic [20:0] QHX_W     = 21'(Q_HX);
    localparam logic [20:0] QHY_W     = 21'(Q_HY);
    localparam logic [10:0] QX_REST   = 11'(X0 + XD);
    localparam logic [9:0]  QY_REST   = 10'(Y0 + YD);
    localparam logic [2:0]  LAST_IDX  = 3'(N_CUBES - 1);
    localparam logic [23:0] RGB_QBERT = 24'hD85F02;
    localparam logic [23:0] RGB_RIGHT = 24'h314646;
    localparam logic [23:0] RGB_LEFT  = 24'h56A998;
    localparam logic [23:0] RGB_BG    = 24'h92A5D8;

    typedef enum logic [2:0] {IDLE, UP, ACROSS, DOWN, LAND, WIN} state_t;

    function automatic logic [20:0] abs_diff(input logic [20:0] a, input logic [20:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // y of the centre of cube k's top diamond
    function automatic logic [20:0] y_top(input int k);
        return 21'(Y0 + YD + 2 * YD * k);
    endfunction

    function automatic logic [23:0] palette(input logic [2:0] c);
        case (c)
            3'd0:    return 24'hDEDE00;
            3'd1:    return 24'h5646EF;
            3'd2:    return 24'h00FF40;
            3'd3:    return 24'h84239C;
            3'd4:    return 24'hAA0D28;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    function automatic logic [2:0] color_inc(input logic [2:0] c);
        return (c == 3'(N_COLORS - 1)) ? 3'd0 : c + 3'd1;
    endfunction

    state_t      state;
    logic [31:0] tick_cnt;
    logic [15:0] step_cnt;
    logic [10:0] qx;
    logic [9:0]  qy;
    logic        dir;          // 1: moving towards higher cube index
    logic [2:0]  tgt_idx;
    logic [2:0]  color     [8];
    logic [2:0]  color_upd [8];
    logic        nxt_dir;
    logic [2:0]  nxt_tgt;
    logic        step_end;
    logic [23:0] bg_rgb;

    logic        q_hit, top_hit, right_hit, left_hit;
    logic [2:0]  top_idx;
    logic        q_hit_p1, top_hit_p1, right_hit_p1, left_hit_p1;
    logic [2:0]  top_idx_p1;

    assign step_end = (tick_cnt == 32'(STEP_TICKS - 1));

    // Direction is decided at hop start: bounce off either end of the row.
    always_comb begin
        nxt_dir = dir;
        nxt_tgt = qbert_idx;
        if (N_CUBES > 1) begin
            if (qbert_idx == LAST_IDX)
                nxt_dir = 1'b0;
            else if (qbert_idx == 3'd0)
                nxt_dir = 1'b1;
            nxt_tgt = nxt_dir ? (qbert_idx + 3'd1) : (qbert_idx - 3'd1);
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            color_upd[k] = color[k];
            if (k < N_CUBES && 3'(k) == tgt_idx)
                color_upd[k] = color_inc(color[k]);
        end
    end

`ifdef QBERT_WIN_EN
    logic        all_tgt;
    logic [22:0] blink_cnt;

    always_comb begin
        all_tgt = 1'b1;
        for (int k = 0; k < N_CUBES; k++)
            if (color_upd[k] != 3'(TARGET_COLOR))
                all_tgt = 1'b0;
    end

    assign bg_rgb = (state == WIN && blink_cnt[22]) ? 24'hFFFFFF : RGB_BG;
`else
    assign bg_rgb     = RGB_BG;
    assign level_done = 1'b0;
`endif

    // Hop FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            step_cnt  <= '0;
            qx        <= QX_REST;
            qy        <= QY_REST;
            dir       <= 1'b1;
            tgt_idx   <= '0;
            qbert_idx <= '0;
            hop_done  <= 1'b0;
            for (int k = 0; k < 8; k++)
                color[k] <= '0;
`ifdef QBERT_WIN_EN
            level_done <= 1'b0;
            blink_cnt  <= '0;
`endif
        end else begin
            hop_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick_cnt == 32'(IDLE_TICKS - 1)) begin
                        tick_cnt <= '0;
                        dir      <= nxt_dir;
                        tgt_idx  <= nxt_tgt;
                        state    <= UP;
                    end else begin
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                end
                UP: begin
                    if (step_end) begin
                        tick_cnt <= '0;
                        qx       <= qx - 11'd1;
                        if (step_cnt == 16'(HOP_H - 1)) begin
                            step_cnt <= '0;
                            state    <= (N_CUBES > 1) ? ACROSS : DOWN;
                        end else begin
                            step_cnt <= step_cnt + 16'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                end
                ACROSS: begin
                    if (step_end) begin
                        tick_cnt <= '0;
                        qy       <= dir ? (qy + 10'd1) : (qy - 10'd1);
                        if (step_cnt == 16'(2 * YD - 1)) begin
                            step_cnt <= '0;
                            state    <= DOWN;
                        end else begin
                            step_cnt <= step_cnt + 16'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                end
                DOWN: begin
                    if (step_end) begin
                        tick_cnt <= '0;
                        qx       <= qx + 11'd1;
                        if (step_cnt == 16'(HOP_H - 1)) begin
                            step_cnt <= '0;
                            hop_done <= 1'b1;
                            state    <= LAND;
                        end else begin
                            step_cnt <= step_cnt + 16'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                end
                LAND: begin
                    qbert_idx <= tgt_idx;
                    for (int k = 0; k < 8; k++)
                        color[k] <= color_upd[k];
`ifdef QBERT_WIN_EN
                    if (all_tgt) begin
                        level_done <= 1'b1;
                        blink_cnt  <= '0;
                        state      <= WIN;
                    end else begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
`ifdef QBERT_WIN_EN
                WIN: begin
                    blink_cnt <= blink_cnt + 23'd1;
                    if (tick_cnt == 32'(WIN_TICKS - 1)) begin
                        tick_cnt   <= '0;
                        level_done <= 1'b0;
                        for (int k = 0; k < 8; k++)
                            color[k] <= '0;
                        state <= IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Region tests for the current pixel; lower cube index wins on overlap.
    always_comb begin : region_p0
        logic [20:0] px, py, dx, dy, yt;
        logic        x_side;
        px        = 21'(x_cnt);
        py        = 21'(y_cnt);
        dx        = abs_diff(px, XT_W);
        dy        = '0;
        yt        = '0;
        x_side    = (px > XT_W) && (px <= XT_W + XLEN_W);
        top_hit   = 1'b0;
        top_idx   = '0;
        right_hit = 1'b0;
        left_hit  = 1'b0;
        for (int k = N_CUBES - 1; k >= 0; k--) begin
            yt = y_top(k);
            dy = abs_diff(py, yt);
            if (dx * YD_W + dy * XD_W <= AREA_W) begin
                top_hit = 1'b1;
                top_idx = 3'(k);
            end
            if (x_side && py >= yt - YD_W && py < yt)
                left_hit = 1'b1;
            if (x_side && py >= yt && py <= yt + YD_W)
                right_hit = 1'b1;
        end
        q_hit = (abs_diff(px, 21'(qx)) <= QHX_W) && (abs_diff(py, 21'(qy)) <= QHY_W);
    end

    // Stage 1: registered region flags
    always_ff @(posedge clk) begin
        q_hit_p1     <= q_hit;
        top_hit_p1   <= top_hit;
        top_idx_p1   <= top_idx;
        right_hit_p1 <= right_hit;
        left_hit_p1  <= left_hit;
    end

    // Stage 2: registered priority colour mux
    always_ff @(posedge clk) begin
        if (reset)
            menu_RGB <= '0;
        else if (q_hit_p1)
            menu_RGB <= RGB_QBERT;
        else if (top_hit_p1)
            menu_RGB <= palette(color[top_idx_p1]);
        else if (right_hit_p1)
            menu_RGB <= RGB_RIGHT;
        else if (left_hit_p1)
            menu_RGB <= RGB_LEFT;
        else
            menu_RGB <= bg_rgb;
    end

endmodule

// File: tb/tb_qbert_row_menu.sv
module tb_qbert_row_menu;

    // Small-geometry instances: XT = 110+4, YT0 = 350+4
    localparam int XT  = 114;
    localparam int YT0 = 354;
    // Default-geometry instance: XT = 190, YT0 = 450, YT1 = 650
    localparam int DXT  = 190;
    localparam int DYT0 = 450;
    localparam int DYT1 = 650;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x_cnt = '0;
    logic [9:0]  y_cnt = '0;

    logic [23:0] rgb3, rgb1, rgb2, rgb5;
    logic        hd3, hd1, hd2, hd5;
    logic        ld3, ld1, ld2, ld5;
    logic [2:0]  idx3, idx1, idx2, idx5;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qbert_row_menu #(.N_CUBES(3), .IDLE_TICKS(4), .STEP_TICKS(2), .HOP_H(2),
                     .YD(4), .XD(4), .XLEN(4), .Q_HX(1), .Q_HY(1)) u3 (
        .clk(clk), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt),
        .menu_RGB(rgb3), .hop_done(hd3), .level_done(ld3), .qbert_idx(idx3));

    qbert_row_menu #(.N_CUBES(1), .IDLE_TICKS(4), .STEP_TICKS(2), .HOP_H(2),
                     .YD(4), .XD(4), .XLEN(4), .Q_HX(1), .Q_HY(1)) u1 (
        .clk(clk), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt),
        .menu_RGB(rgb1), .hop_done(hd1), .level_done(ld1), .qbert_idx(idx1));

    qbert_row_menu #(.N_CUBES(2), .TARGET_COLOR(1), .WIN_TICKS(10),
                     .IDLE_TICKS(4), .STEP_TICKS(2), .HOP_H(2),
                     .YD(4), .XD(4), .XLEN(4), .Q_HX(1), .Q_HY(1)) u2 (
        .clk(clk), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt),
        .menu_RGB(rgb2), .hop_done(hd2), .level_done(ld2), .qbert_idx(idx2));

    qbert_row_menu #(.IDLE_TICKS(4), .STEP_TICKS(2)) u5 (
        .clk(clk), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt),
        .menu_RGB(rgb5), .hop_done(hd5), .level_done(ld5), .qbert_idx(idx5));

    // Leaves the bench 1 time unit into cycle 1 (first cycle after the reset edge).
    task automatic apply_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rgb3 !== 24'h0) begin failures++; $display("FAIL rst_rgb: got %h want 000000", rgb3); end
        checks++;
        if (hd3 !== 1'b0 || ld3 !== 1'b0) begin
            failures++; $display("FAIL rst_flags: hop_done=%b level_done=%b want 0 0", hd3, ld3);
        end
        checks++;
        if (idx3 !== 3'd0) begin failures++; $display("FAIL rst_idx: got %0d want 0", idx3); end
        checks++;
        if (u3.qx !== 11'(XT) || u3.qy !== 10'(YT0)) begin
            failures++; $display("FAIL rst_pos: got qx=%0d qy=%0d want %0d %0d", u3.qx, u3.qy, XT, YT0);
        end
        checks++;
        if (u3.color[0] !== 3'd0 || u3.color[1] !== 3'd0 || u3.color[2] !== 3'd0) begin
            failures++; $display("FAIL rst_color: got %0d %0d %0d want 0 0 0", u3.color[0], u3.color[1], u3.color[2]);
        end
    endtask

    task automatic test_hop_sequence;
        int exp_idx [5] = '{1, 2, 1, 0, 1};
        int cyc, prev;
        bit found;
        apply_reset();
        cyc = 1;
        prev = 0;
        for (int h = 0; h < 5; h++) begin
            found = 0;
            for (int n = 0; n < 40; n++) begin
                if (hd3 === 1'b1) begin found = 1; break; end
                @(posedge clk); #1; cyc++;
            end
            checks++;
            if (!found) begin
                failures++; $display("FAIL hop3_timeout: hop %0d got no hop_done want one within 40 cycles", h);
                return;
            end
            checks++;
            if (cyc - prev != 29) begin
                failures++; $display("FAIL hop3_period: hop %0d got %0d cycles want 29", h, cyc - prev);
            end
            prev = cyc;
            @(posedge clk); #1; cyc++;
            checks++;
            if (idx3 !== 3'(exp_idx[h])) begin
                failures++; $display("FAIL hop3_idx: hop %0d got %0d want %0d", h, idx3, exp_idx[h]);
            end
            checks++;
            if (hd3 !== 1'b0) begin failures++; $display("FAIL hop3_pulse: hop %0d got hop_done=1 want 0", h); end
            if (h == 0) begin
                checks++;
                if (u3.color[1] !== 3'd1) begin
                    failures++; $display("FAIL hop3_color1: got %0d want 1", u3.color[1]);
                end
            end
        end
    endtask

    task automatic test_single_cube;
        int exp_col [5] = '{1, 2, 3, 4, 0};
        int cyc, prev;
        bit found, qy_moved;
        apply_reset();
        cyc = 1;
        prev = 0;
        qy_moved = 0;
        for (int h = 0; h < 5; h++) begin
            found = 0;
            for (int n = 0; n < 20; n++) begin
                if (u1.qy !== 10'(YT0)) qy_moved = 1;
                if (hd1 === 1'b1) begin found = 1; break; end
                @(posedge clk); #1; cyc++;
            end
            checks++;
            if (!found) begin
                failures++; $display("FAIL hop1_timeout: hop %0d got no hop_done want one within 20 cycles", h);
                return;
            end
            checks++;
            if (cyc - prev != 13) begin
                failures++; $display("FAIL hop1_period: hop %0d got %0d cycles want 13", h, cyc - prev);
            end
            prev = cyc;
            @(posedge clk); #1; cyc++;
            checks++;
            if (u1.color[0] !== 3'(exp_col[h]) || idx1 !== 3'd0) begin
                failures++; $display("FAIL hop1_color: hop %0d got color=%0d idx=%0d want %0d 0", h, u1.color[0], idx1, exp_col[h]);
            end
        end
        checks++;
        if (qy_moved) begin failures++; $display("FAIL hop1_qy: got qy moving want constant %0d", YT0); end
    endtask

    task automatic test_win;
        int exp_land [3] = '{1, 0, 1};
        int n;
        bit found, ld_seen;
        apply_reset();
        ld_seen = 0;
        for (int h = 0; h < 2; h++) begin
            found = 0;
            for (int k = 0; k < 40; k++) begin
                if (ld2 === 1'b1) ld_seen = 1;
                if (hd2 === 1'b1) begin found = 1; break; end
                @(posedge clk); #1;
            end
            checks++;
            if (!found) begin
                failures++; $display("FAIL win_hop_timeout: hop %0d got no hop_done want one within 40 cycles", h);
                return;
            end
            if (h == 1) begin
                checks++;
                if (ld2 !== 1'b0) begin failures++; $display("FAIL win_ld_land: got level_done=1 in LAND want 0"); end
            end
            @(posedge clk); #1;
            checks++;
            if (idx2 !== 3'(exp_land[h])) begin
                failures++; $display("FAIL win_idx: hop %0d got %0d want %0d", h, idx2, exp_land[h]);
            end
        end
`ifdef QBERT_WIN_EN
        checks++;
        if (ld2 !== 1'b1) begin failures++; $display("FAIL win_rise: got level_done=%b want 1", ld2); end
        n = 0;
        while (ld2 === 1'b1 && n < 30) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != 10) begin failures++; $display("FAIL win_len: got %0d cycles want 10", n); end
        checks++;
        if (u2.color[0] !== 3'd0 || u2.color[1] !== 3'd0) begin
            failures++; $display("FAIL win_clear: got %0d %0d want 0 0", u2.color[0], u2.color[1]);
        end
        checks++;
        if (idx2 !== 3'd0 || u2.qy !== 10'(YT0)) begin
            failures++; $display("FAIL win_stay: got idx=%0d qy=%0d want 0 %0d", idx2, u2.qy, YT0);
        end
`else
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (ld2 === 1'b1) ld_seen = 1;
            if (hd2 === 1'b1) begin found = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL nowin_hop_timeout: got no third hop_done want one within 40 cycles");
            return;
        end
        @(posedge clk); #1;
        checks++;
        if (u2.color[1] !== 3'd2 || u2.color[0] !== 3'd1 || idx2 !== 3'(exp_land[2])) begin
            failures++; $display("FAIL nowin_color: got c0=%0d c1=%0d idx=%0d want 1 2 1", u2.color[0], u2.color[1], idx2);
        end
        checks++;
        if (ld_seen || ld2 !== 1'b0) begin failures++; $display("FAIL nowin_ld: got level_done asserted want never"); end
`endif
    endtask

    task automatic test_pixels;
        int px [6]  = '{DXT, DXT + 30, DXT, DXT + 100, DXT + 100, 0};
        int py [6]  = '{DYT1, DYT1, DYT0, DYT0 - 1, DYT0, 0};
        logic [23:0] exp_rgb [6];
        string nm [6] = '{"pix_qbert", "pix_top1", "pix_top0", "pix_left", "pix_right", "pix_bg"};
        bit found;
        exp_rgb[0] = 24'hD85F02;
        exp_rgb[1] = 24'h5646EF;
        exp_rgb[2] = 24'hDEDE00;
        exp_rgb[3] = 24'h56A998;
        exp_rgb[4] = 24'h314646;
        exp_rgb[5] = 24'h92A5D8;
        apply_reset();
        found = 0;
        for (int k = 0; k < 700; k++) begin
            if (hd5 === 1'b1) begin found = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL pix_hop_timeout: got no hop_done want one within 700 cycles");
            return;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            x_cnt = 11'(px[i]);
            y_cnt = 10'(py[i]);
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if (rgb5 !== exp_rgb[i]) begin
                failures++; $display("FAIL %s: got %h want %h", nm[i], rgb5, exp_rgb[i]);
            end
        end
    endtask

    task automatic test_reset_mid_hop;
        apply_reset();
        repeat (13) @(posedge clk);
        #1;
        checks++;
        if (u3.qy !== 10'(YT0 + 2) || u3.qx !== 11'(XT - 2)) begin
            failures++; $display("FAIL across_pos: got qx=%0d qy=%0d want %0d %0d", u3.qx, u3.qy, XT - 2, YT0 + 2);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (u3.qy !== 10'(YT0) || u3.qx !== 11'(XT)) begin
            failures++; $display("FAIL midrst_pos: got qx=%0d qy=%0d want %0d %0d", u3.qx, u3.qy, XT, YT0);
        end
        checks++;
        if (idx3 !== 3'd0 || hd3 !== 1'b0 || ld3 !== 1'b0 || rgb3 !== 24'h0) begin
            failures++; $display("FAIL midrst_out: got idx=%0d hd=%b ld=%b rgb=%h want 0 0 0 000000", idx3, hd3, ld3, rgb3);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hop_sequence();
        test_single_cube();
        test_win();
        test_pixels();
        test_reset_mid_hop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
